nibble_serial_adder: RTL

//  Multi-cycle wide adder built around one 4-bit ripple-carry slice.
//  - Adds WIDTH-bit operands one nibble per clock, LSB nibble first.
//  - A registered carry links each nibble to the next.
//  - Sits in the DSD lab datapath, directly downstream of operand entry; extends the 4-bit RCA stage to wider words.
//  - Returns sum and carry-out with a start/busy/done handshake.

---
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder built on one 4-bit ripple-carry slice
//
// Adds two WIDTH-bit operands one nibble per clock, LSB nibble first, with a
// registered carry linking each nibble to the next.
//
// Optional feature macro: NSA_SUB_EN
//   defined   : sub sampled with start; sub=1 computes a - b as a + ~b + 1,
//               cout=1 means no borrow.
//   undefined : sub ignored, add only.
//
// Parameters:
//   WIDTH  operand/sum width in bits; multiple of 4, >= 4
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; a, b, sub sampled when accepted (IDLE or DONE)
//   a, b   operands
//   sub    subtract select (NSA_SUB_EN only)
//   busy   high while nibbles are being processed
//   done   one-cycle pulse; sum/cout valid from this cycle
//   sum    result, held until the next result completes
//   cout   carry out of the MSB nibble, held with sum

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB) + 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry_reg;

    logic [4:0]       slice;
    logic [WIDTH+3:0] res_cat;
    logic [WIDTH-1:0] res_next;

`ifndef NSA_SUB_EN
    logic sub_unused;
    assign sub_unused = sub;
`endif

    // Operands shift right so the current nibble is always in bits [3:0];
    // result nibbles enter at the top and shift down, so after NIB steps
    // the first nibble has reached bits [3:0].
    assign slice    = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_reg};
    assign res_cat  = {slice[3:0], res};
    assign res_next = res_cat[WIDTH+3:4];

    assign busy = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cnt       <= '0;
            carry_reg <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh <= a;
`ifdef NSA_SUB_EN
                        b_sh      <= sub ? ~b : b;
                        carry_reg <= sub;
`else
                        b_sh      <= b;
                        carry_reg <= 1'b0;
`endif
                        res   <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh      <= a_sh >> 4;
                    b_sh      <= b_sh >> 4;
                    res       <= res_next;
                    carry_reg <= slice[4];
                    cnt       <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= slice[4];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
